// File: rtl/dmem_pipe_if.sv
// rtl/dmem_pipe_if.sv - request/response bus between the memory stage and dmem_pipe
interface dmem_pipe_if #(
  parameter int DATA_W = 64
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [63:0]           req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic [DATA_W/8-1:0]   req_be;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_W-1:0]     resp_rdata;
  logic                  resp_error;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/dmem_pipe.sv
// rtl/dmem_pipe.sv - byte-enabled data memory with one outstanding request and LAT-cycle response
module dmem_pipe #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8192,
  parameter int LAT    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  dmem_pipe_if.slave bus
);
  localparam int          BYTES      = DATA_W / 8;
  localparam int          OFF_W      = $clog2(BYTES);
  localparam int          IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] ALIGN_MASK = 64'(BYTES - 1);
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'(BYTES);
  localparam logic [2:0]  CNT_INIT   = 3'(LAT - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              error_q, error_d;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic              accept;
  logic              addr_err;
  logic [IDX_W-1:0]  idx;

  // Range check uses the full 64-bit address so high garbage bits can never alias a valid word.
  assign accept   = (state_q == IDLE) && bus.req_valid;
  assign addr_err = ((bus.req_addr & ALIGN_MASK) != '0) || (bus.req_addr >= ADDR_LIMIT);
  assign idx      = IDX_W'(bus.req_addr >> OFF_W);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          error_d = addr_err;
          rdata_d = (addr_err || bus.req_write) ? '0 : mem_q[idx];
          cnt_d   = CNT_INIT;
          state_d = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (bus.resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Array is not reset; gating on rst_n makes a reset coinciding with acceptance suppress the write.
  always_ff @(posedge clk) begin
    if (rst_n && accept && bus.req_write && !addr_err) begin
      for (int k = 0; k < BYTES; k++) begin
        if (bus.req_be[k]) begin
          mem_q[idx][k*8 +: 8] <= bus.req_wdata[k*8 +: 8];
        end
      end
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;
endmodule
